// File: rtl/go_pkg.sv
// Shared types and constants for the 9x9 Go turn controller datapath.
// Also hosts the colour-toggle helper used wherever the turn advances.
package go_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    typedef cell_t [8:0][8:0] board_t;

    localparam int         BOARD_N   = 32'd9;
    localparam logic [7:0] PASS_MOVE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        WRITE = 3'd2,
        PASS  = 3'd3,
        TX    = 3'd4,
        OVER  = 3'd5
    } ctrl_state_t;

    function automatic cell_t other_color(input cell_t c);
        return (c == BLACK) ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/go_turn_ctrl_if.sv
// Move request / transmit handshake bundle between the players and the turn controller.
// The master side is the environment; the slave side is the controller.
interface go_turn_ctrl_if;
    logic       local_valid;
    logic [7:0] local_move;
    logic       local_ack;
    logic       local_nack;
    logic       rx_ready;
    logic [7:0] rx_move;
    logic       tx_valid;
    logic [7:0] tx_move;
    logic       tx_ready;

    modport master (
        output local_valid, local_move, rx_ready, rx_move, tx_ready,
        input  local_ack, local_nack, tx_valid, tx_move
    );

    modport slave (
        input  local_valid, local_move, rx_ready, rx_move, tx_ready,
        output local_ack, local_nack, tx_valid, tx_move
    );
endinterface

// File: rtl/go_move_decode.sv
// Combinational move decoder: splits row/col and flags pass and on-board moves.
module go_move_decode
    import go_pkg::*;
#(
    parameter int BOARD_N = go_pkg::BOARD_N
) (
    input  logic [7:0] move,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       is_pass,
    output logic       in_range
);
    localparam logic [3:0] MAX_IDX = 4'(BOARD_N - 1);

    assign row      = move[7:4];
    assign col      = move[3:0];
    assign is_pass  = (move == PASS_MOVE);
    assign in_range = (row <= MAX_IDX) && (col <= MAX_IDX);
endmodule

// File: rtl/go_turn_ctrl.sv
// Turn sequencer and board owner: admits on-turn moves, validates them against the
// stored board, writes legal stones, forwards local moves to the link and tracks passes.
module go_turn_ctrl
    import go_pkg::*;
#(
    parameter cell_t LOCAL_COLOR = BLACK,
    parameter int    BOARD_N     = go_pkg::BOARD_N
) (
    input  logic                 clk_in,
    input  logic                 reset,
    go_turn_ctrl_if.slave        bus,
    output board_t               board,
    output cell_t                turn,
    output logic                 game_over,
    output logic                 illegal
);
    ctrl_state_t state_r, state_nxt_s;
    board_t      board_r;
    cell_t       turn_r, turn_nxt_s;
    logic [1:0]  pass_cnt_r, pass_cnt_nxt_s, pass_inc_s;
    logic [7:0]  move_r, latch_move_s, tx_move_r, tx_move_nxt_s;
    logic        src_local_r, latch_src_s, latch_s, board_we_s;
    logic        local_ack_r, local_ack_nxt_s, local_nack_r, local_nack_nxt_s;
    logic        illegal_r, illegal_nxt_s, tx_valid_r, tx_valid_nxt_s;
    logic        game_over_r;
    logic [3:0]  row_s, col_s, row_idx_s, col_idx_s;
    logic        is_pass_s, in_range_s, occupied_s, reject_s, my_turn_s, local_req_s;

    go_move_decode #(.BOARD_N(BOARD_N)) u_decode (
        .move     (move_r),
        .row      (row_s),
        .col      (col_s),
        .is_pass  (is_pass_s),
        .in_range (in_range_s)
    );

    // Off-board indices are parked at 0 so the board lookup never leaves the array.
    assign row_idx_s  = in_range_s ? row_s : 4'd0;
    assign col_idx_s  = in_range_s ? col_s : 4'd0;
    assign occupied_s = (board_r[row_idx_s][col_idx_s] != EMPTY);
    assign reject_s   = !in_range_s || occupied_s;
    assign my_turn_s  = (turn_r == LOCAL_COLOR);
    // A request just nacked is still held high for a cycle; do not answer it twice.
    assign local_req_s = bus.local_valid && !local_nack_r;
    assign pass_inc_s  = (pass_cnt_r == 2'd2) ? 2'd2 : (pass_cnt_r + 2'd1);

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (my_turn_s) begin
                    state_nxt_s = local_req_s ? CHECK : IDLE;
                end else begin
                    state_nxt_s = bus.rx_ready ? CHECK : IDLE;
                end
            end
            CHECK: begin
                if (is_pass_s) begin
                    state_nxt_s = PASS;
                end else if (reject_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            WRITE:   state_nxt_s = src_local_r ? TX : IDLE;
            PASS: begin
                if (src_local_r) begin
                    state_nxt_s = TX;
                end else begin
                    state_nxt_s = (pass_inc_s == 2'd2) ? OVER : IDLE;
                end
            end
            TX: begin
                if (bus.tx_ready && tx_valid_r) begin
                    state_nxt_s = (pass_cnt_r == 2'd2) ? OVER : IDLE;
                end else begin
                    state_nxt_s = TX;
                end
            end
            OVER:    state_nxt_s = OVER;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output and datapath next values; all of these are registered below.
    always_comb begin
        local_ack_nxt_s  = 1'b0;
        local_nack_nxt_s = 1'b0;
        illegal_nxt_s    = 1'b0;
        tx_valid_nxt_s   = tx_valid_r;
        tx_move_nxt_s    = tx_move_r;
        pass_cnt_nxt_s   = pass_cnt_r;
        turn_nxt_s       = turn_r;
        board_we_s       = 1'b0;
        latch_s          = 1'b0;
        latch_move_s     = move_r;
        latch_src_s      = src_local_r;
        case (state_r)
            IDLE: begin
                if (my_turn_s) begin
                    latch_s       = local_req_s;
                    latch_move_s  = bus.local_move;
                    latch_src_s   = 1'b1;
                    illegal_nxt_s = bus.rx_ready;
                end else begin
                    latch_s          = bus.rx_ready;
                    latch_move_s     = bus.rx_move;
                    latch_src_s      = 1'b0;
                    local_nack_nxt_s = local_req_s;
                    illegal_nxt_s    = local_req_s;
                end
            end
            CHECK: begin
                if (!is_pass_s && reject_s) begin
                    local_nack_nxt_s = src_local_r;
                    illegal_nxt_s    = 1'b1;
                end else begin
                    local_ack_nxt_s = src_local_r;
                    illegal_nxt_s   = bus.rx_ready;
                end
            end
            WRITE, PASS: begin
                illegal_nxt_s  = bus.rx_ready;
                board_we_s     = (state_r == WRITE);
                pass_cnt_nxt_s = (state_r == WRITE) ? 2'd0 : pass_inc_s;
                if (src_local_r) begin
                    tx_valid_nxt_s = 1'b1;
                    tx_move_nxt_s  = move_r;
                end else begin
                    turn_nxt_s = other_color(turn_r);
                end
            end
            TX: begin
                illegal_nxt_s = bus.rx_ready;
                if (bus.tx_ready && tx_valid_r) begin
                    tx_valid_nxt_s = 1'b0;
                    turn_nxt_s     = other_color(turn_r);
                end else begin
                    tx_valid_nxt_s = tx_valid_r;
                end
            end
            OVER: begin
                illegal_nxt_s = 1'b0;
            end
            default: begin
                illegal_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            board_r      <= board_t'('0);
            turn_r       <= BLACK;
            pass_cnt_r   <= 2'd0;
            move_r       <= 8'h00;
            src_local_r  <= 1'b0;
            local_ack_r  <= 1'b0;
            local_nack_r <= 1'b0;
            illegal_r    <= 1'b0;
            tx_valid_r   <= 1'b0;
            tx_move_r    <= 8'h00;
            game_over_r  <= 1'b0;
        end else begin
            if (latch_s) begin
                move_r      <= latch_move_s;
                src_local_r <= latch_src_s;
            end
            if (board_we_s) begin
                board_r[row_idx_s][col_idx_s] <= turn_r;
            end
            turn_r       <= turn_nxt_s;
            pass_cnt_r   <= pass_cnt_nxt_s;
            local_ack_r  <= local_ack_nxt_s;
            local_nack_r <= local_nack_nxt_s;
            illegal_r    <= illegal_nxt_s;
            tx_valid_r   <= tx_valid_nxt_s;
            tx_move_r    <= tx_move_nxt_s;
            game_over_r  <= (state_nxt_s == OVER);
        end
    end

    assign bus.local_ack  = local_ack_r;
    assign bus.local_nack = local_nack_r;
    assign bus.tx_valid   = tx_valid_r;
    assign bus.tx_move    = tx_move_r;
    assign board          = board_r;
    assign turn           = turn_r;
    assign game_over      = game_over_r;
    assign illegal        = illegal_r;
endmodule

// File: tb/tb_go_turn_ctrl.sv
// Directed bench for go_turn_ctrl: hand-computed expectations checked cycle by cycle.
module tb_go_turn_ctrl;
    import go_pkg::*;

    logic   clk_in = 1'b0;
    logic   reset;
    board_t board;
    cell_t  turn;
    logic   game_over;
    logic   illegal;
    board_t exp_board;
    int     compared = 0;
    int     mismatched = 0;

    go_turn_ctrl_if bus ();

    go_turn_ctrl dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .bus       (bus),
        .board     (board),
        .turn      (turn),
        .game_over (game_over),
        .illegal   (illegal)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [161:0] observed, input logic [161:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.local_valid = 1'b0; bus.local_move = 8'h00;
        bus.rx_ready = 1'b0; bus.rx_move = 8'h00; bus.tx_ready = 1'b0;
        exp_board = board_t'('0);
        step(); step();
        reset = 1'b0;
        step();
        check("rst_board", board, exp_board);
        check("rst_turn", turn, BLACK);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_move", bus.tx_move, 8'h00);
        check("rst_pulses", {bus.local_ack, bus.local_nack, illegal, game_over}, 4'b0000);

        // Local black stone at 4,4, transmitter ready immediately.
        bus.local_valid = 1'b1; bus.local_move = 8'h44; bus.tx_ready = 1'b1;
        step();
        check("l44_c1_ack", bus.local_ack, 1'b0);
        step();
        check("l44_c2_ack", bus.local_ack, 1'b1);
        check("l44_c2_nack", {bus.local_nack, illegal}, 2'b00);
        bus.local_valid = 1'b0;
        step();
        exp_board[4][4] = BLACK;
        check("l44_c3_board", board, exp_board);
        check("l44_c3_tx", {bus.tx_valid, bus.tx_move}, {1'b1, 8'h44});
        check("l44_c3_turn", turn, BLACK);
        check("l44_c3_ack", bus.local_ack, 1'b0);
        step();
        check("l44_c4_turn", turn, WHITE);
        check("l44_c4_tx_valid", bus.tx_valid, 1'b0);
        bus.tx_ready = 1'b0;

        // Remote move onto the occupied 4,4.
        bus.rx_ready = 1'b1; bus.rx_move = 8'h44;
        step();
        bus.rx_ready = 1'b0;
        check("r44_c1_illegal", illegal, 1'b0);
        step();
        check("r44_c2_illegal", illegal, 1'b1);
        step();
        check("r44_c3_illegal", illegal, 1'b0);
        check("r44_c3_board", board, exp_board);
        check("r44_c3_turn", turn, WHITE);

        // Off-turn local request alongside a legal remote move at 0,0.
        bus.local_valid = 1'b1; bus.local_move = 8'h12;
        bus.rx_ready = 1'b1; bus.rx_move = 8'h00;
        step();
        check("off_c1_nack", {bus.local_nack, illegal}, 2'b11);
        bus.local_valid = 1'b0; bus.rx_ready = 1'b0;
        step();
        check("off_c2_pulses", {bus.local_ack, bus.local_nack, illegal}, 3'b000);
        step();
        exp_board[0][0] = WHITE;
        check("r00_c3_board", board, exp_board);
        check("r00_c3_turn", turn, BLACK);

        // Local move with row 9, one past the board edge.
        bus.local_valid = 1'b1; bus.local_move = 8'h9A;
        step();
        check("l9a_c1_nack", bus.local_nack, 1'b0);
        step();
        check("l9a_c2_nack", {bus.local_ack, bus.local_nack, illegal}, 3'b011);
        bus.local_valid = 1'b0;
        step();
        check("l9a_c3_nack", {bus.local_nack, illegal}, 2'b00);
        check("l9a_c3_board", board, exp_board);
        check("l9a_c3_turn", turn, BLACK);

        // Far corner 8,8 with the transmitter stalled; busy rx is rejected.
        bus.local_valid = 1'b1; bus.local_move = 8'h88;
        step(); step();
        check("l88_c2_ack", bus.local_ack, 1'b1);
        bus.local_valid = 1'b0;
        step();
        exp_board[8][8] = BLACK;
        check("l88_c3_board", board, exp_board);
        check("l88_c3_tx", {bus.tx_valid, bus.tx_move}, {1'b1, 8'h88});
        bus.rx_ready = 1'b1; bus.rx_move = 8'h11;
        step();
        bus.rx_ready = 1'b0;
        check("busy_rx_illegal", illegal, 1'b1);
        check("l88_c4_hold", {bus.tx_valid, turn}, {1'b1, BLACK});
        step();
        check("busy_rx_once", illegal, 1'b0);
        check("l88_c5_hold", bus.tx_valid, 1'b1);

        // Reset while the transmit is pending.
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_board = board_t'('0);
        check("mid_rst_tx", {bus.tx_valid, bus.tx_move}, {1'b0, 8'h00});
        check("mid_rst_board", board, exp_board);
        check("mid_rst_turn", turn, BLACK);

        // Local pass then remote pass ends the game.
        bus.local_valid = 1'b1; bus.local_move = 8'hFF; bus.tx_ready = 1'b1;
        step(); step();
        check("lpass_c2_ack", bus.local_ack, 1'b1);
        bus.local_valid = 1'b0;
        step();
        check("lpass_c3_tx", {bus.tx_valid, bus.tx_move}, {1'b1, 8'hFF});
        step();
        check("lpass_c4_turn", {turn, game_over}, {WHITE, 1'b0});
        bus.tx_ready = 1'b0;
        bus.rx_ready = 1'b1; bus.rx_move = 8'hFF;
        step();
        bus.rx_ready = 1'b0;
        step();
        check("rpass_c2_over", game_over, 1'b0);
        step();
        check("rpass_c3_turn", turn, BLACK);
        check("rpass_c3_over", game_over, 1'b1);

        // Requests after game over are ignored.
        bus.local_valid = 1'b1; bus.local_move = 8'h33;
        bus.rx_ready = 1'b1; bus.rx_move = 8'h22;
        for (int i = 0; i < 3; i++) begin
            step();
            check("over_quiet", {bus.local_ack, bus.local_nack, illegal, bus.tx_valid}, 4'b0000);
        end
        bus.local_valid = 1'b0; bus.rx_ready = 1'b0;
        check("over_board", board, exp_board);
        check("over_hold", {game_over, turn}, {1'b1, BLACK});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/go_turn_ctrl.md
# go_turn_ctrl

Turn sequencer and board owner for the 9x9 Go datapath. It arbitrates between moves from the local player and moves received over the comm link, and admits a request only when it is that side's turn. Admitted moves are validated against the stored board; legal stones are written and the turn advances. Local moves and passes are forwarded to the comm transmitter. The block feeds the board mux / display with the authoritative board and current turn.

## Interface
Parameters:
- LOCAL_COLOR, default 2'b01 (black): colour played by the local side; remote plays the other colour.
- BOARD_N, default 9: board edge length; row/col indices 0..BOARD_N-1.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- local_valid  in  1  local move request; level, held until local_ack or local_nack.
- local_move  in  8  [7:4] row, [3:0] col; 8'hFF = pass.
- local_ack  out  1  one-cycle pulse: local move accepted.
- local_nack  out  1  one-cycle pulse: local move rejected (off-turn or illegal).
- rx_ready  in  1  one-cycle pulse: remote move on rx_move.
- rx_move  in  8  same encoding as local_move.
- tx_valid  out  1  local move/pass to transmit; held until tx_ready.
- tx_move  out  8  move being transmitted; stable while tx_valid.
- tx_ready  in  1  transmitter accepts tx_move when high with tx_valid.
- board  out  2 x [8:0][8:0]  stored board, cell 00 empty / 01 black / 10 white.
- turn  out  2  colour to move (01 or 10).
- game_over  out  1  high after two consecutive passes.
- illegal  out  1  one-cycle pulse on any rejected move (local or remote).

## Operation
- Reset:
  - board all 00; turn=01; pass_cnt=0; state IDLE.
  - local_ack, local_nack, illegal, tx_valid, game_over = 0; tx_move = 0.
- IDLE:
  - When turn==LOCAL_COLOR and local_valid: latch local_move, src=LOCAL, go to CHECK.
  - When turn!=LOCAL_COLOR and rx_ready: latch rx_move, src=REMOTE, go to CHECK.
  - Off-turn local_valid: local_nack + illegal next cycle; request dropped.
  - Off-turn rx_ready: illegal next cycle; request dropped.
- CHECK:
  - Move 8'hFF goes to PASS.
  - Row or col > BOARD_N-1, or target cell != 00: reject. illegal pulses (plus local_nack if src=LOCAL), return to IDLE, turn unchanged.
  - Otherwise go to WRITE.
- WRITE: board[row][col] <= turn; pass_cnt <= 0; local_ack if LOCAL.
- PASS: pass_cnt <= pass_cnt+1 (saturate at 2); local_ack if LOCAL.
- From WRITE or PASS:
  - src=LOCAL: go to TX.
  - src=REMOTE: toggle turn, then go to OVER if pass_cnt==2, else IDLE.
- TX: tx_valid=1, tx_move = latched move. On tx_ready: drop tx_valid, toggle turn, go to OVER if pass_cnt==2, else IDLE.
- OVER: game_over=1. All requests are ignored and no pulses are produced. Only reset exits.
- Scope: no capture, ko or scoring logic in this block.

## Timing
- Cycle 0: request sampled in IDLE.
- Cycle 1: CHECK.
- Cycle 2: WRITE/PASS. local_ack, or local_nack + illegal, is high during this cycle.
- Cycle 3: board shows the new stone. For a remote move, turn is also toggled at cycle 3. For a local move, tx_valid is high at cycle 3 at the earliest.
- Local turn toggles the cycle after the tx_ready handshake. tx_ready already high at cycle 3 gives a toggle at cycle 4.
- Off-turn rejects: pulses in cycle 1; FSM remains in IDLE.
- rx_ready while not IDLE (busy): illegal pulse next cycle, move dropped.
- local_valid while busy: no response until IDLE.
- Pulse outputs are registered and exactly one cycle wide.
- Reset mid-operation (any state, including TX): all state cleared the next cycle and any pending tx is dropped.

## Structure
- Package go_pkg:
  - cell_t enum (EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10).
  - board_t typedef ([8:0][8:0] cell_t).
  - BOARD_N, PASS_MOVE=8'hFF.
  - ctrl_state_t enum (IDLE, CHECK, WRITE, PASS, TX, OVER).
- Sub-module go_move_decode: combinational. Splits the move into row/col and produces is_pass and in_range. Used once in CHECK.

## Test plan
- After reset, local (black) move 8'h44 with tx_ready=1 → cycle 2 local_ack; cycle 3 board[4][4]=01, tx_valid, tx_move=8'h44; cycle 4 turn=10.
- Remote rx_move 8'h44 (occupied) during white turn → illegal pulse at cycle 2; board and turn unchanged.
- Local 8'h9A (row 9 out of range) → local_nack + illegal; board unchanged.
- Off-turn local_valid with simultaneous rx_ready 8'h00 during white turn → local_nack + illegal at cycle 1; remote stone accepted, board[0][0]=10 at cycle 3, turn=01.
- Local pass, then remote pass → game_over=1 after the second toggle; later requests produce no ack, nack or illegal.
- Reset asserted while tx_valid is held (tx_ready=0) → next cycle tx_valid=0, board empty, turn=01, state IDLE.
